pipe_stage_skid_reg: RTL and testbench

- Generic, parametrised pipeline-stage register for the pipelined CPU.
- Replaces the fixed-field IF/ID stall register with a valid/ready handshake, synchronous flush with bubble insertion, and an optional 2-entry skid buffer.
- The skid buffer breaks the combinational ready path.
- Instantiated between any two stages (IF/ID, ID/EX, ...) with the payload packed into one bus, e.g. {pc, pcplus4, instr}.

---
 rtl/pipe_stage_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that registers the upstream ready.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W     = 96,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = 96'h0000_0000_0000_0000_0000_0013,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer, out_xfer;

  assign out_valid_o = (state_q != S_EMPTY);
  assign out_data_o  = main_q;
  assign stall_cnt_o = cnt_q;

  // With the skid buffer, ready depends on state only, cutting the path
  // from out_ready_i back to the upstream stage.
  assign in_ready_o = SKID ? (state_q != S_FULL) : (~out_valid_o | out_ready_i);

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_d  = in_data_i;
          end
        end
        S_ONE: begin
          // Without a skid buffer, in_xfer in ONE implies out_xfer, so FULL is unreachable.
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end else if (in_xfer) begin
            state_d = S_FULL;
            skid_d  = in_data_i;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_o && !out_ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench: lane 0 is the combinational-ready build (4-bit counter),
// lane 1 the skid-buffer build (16-bit counter); both see the same stimulus.
module tb_pipe_stage_skid_reg;
  localparam int W = 96;
  localparam logic [W-1:0] BUB = 96'h0000_0000_0000_0000_0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush[2];
  logic         in_valid[2];
  logic [W-1:0] in_data[2];
  logic         out_ready[2];
  logic         in_ready[2];
  logic         out_valid[2];
  logic [W-1:0] out_data[2];
  logic [3:0]   cnt0;
  logic [15:0]  cnt1;
  logic [15:0]  cnt[2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cnt[0] = {12'd0, cnt0};
  assign cnt[1] = cnt1;

  pipe_stage_skid_reg #(.DATA_W(W), .SKID(1'b0), .BUBBLE_VAL(BUB), .CNT_W(4)) u_comb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .stall_cnt_o(cnt0)
  );

  pipe_stage_skid_reg #(.DATA_W(W), .SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(16)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .stall_cnt_o(cnt1)
  );

  task automatic chk(input string nm, input int g, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d actual=%h expected=%h t=%0t", nm, g, act, exp, $time);
    end
  endtask

  // Reference model per lane: a FIFO of accepted-but-not-consumed payloads.
  // Skid build holds up to 2, the combinational build up to 1.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam logic [15:0] CMAX = (g == 0) ? 16'h000f : 16'hffff;
    logic [W-1:0] q[$];
    logic [W-1:0] last;
    logic [15:0]  ecnt;
    logic         acc;

    // Stimulus side: predict ready, then record what the stage accepts.
    initial begin
      forever begin
        @(negedge clk);
        #1;
        if (rst)         acc = 1'b1;
        else if (g == 1) acc = (q.size() < 2);
        else             acc = (q.size() == 0) || out_ready[g];
        chk("in_ready", g, {95'd0, in_ready[g]}, {95'd0, acc});
        #2;
        if (!rst) begin
          if (flush[g]) begin
            q.delete();
            last = BUB;
          end else if (in_valid[g] && acc) begin
            q.push_back(in_data[g]);
          end
        end
      end
    end

    // Monitor: compare outputs, consume on downstream transfer.
    initial begin
      logic [W-1:0] exp_d;
      last = BUB;
      ecnt = '0;
      forever begin
        @(negedge clk);
        #2;
        if (rst) begin
          q.delete();
          last = BUB;
          ecnt = '0;
        end
        if (q.size() > 0) exp_d = q[0];
        else              exp_d = last;
        chk("out_valid", g, {95'd0, out_valid[g]}, {95'd0, (q.size() > 0)});
        chk("out_data", g, out_data[g], exp_d);
        chk("stall_cnt", g, {80'd0, cnt[g]}, {80'd0, ecnt});
        if (!rst && q.size() > 0) begin
          if (out_ready[g]) last = q.pop_front();
          else if (ecnt != CMAX) ecnt++;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = v;
      in_data[g]   = d;
      out_ready[g] = ordy;
      flush[g]     = fl;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b1; flush[g] = 1'b0;
    end
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a stream, then a clean A/B stream.
    cyc(1'b1, 96'h11, 1'b1, 1'b0);
    cyc(1'b1, 96'h12, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 96'h13, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 96'h1, 1'b1, 1'b0);
    cyc(1'b1, 96'h2, 1'b1, 1'b0);
    cyc(1'b0, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    cyc(1'b0, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);

    // Backpressure: A accepted, B and C offered while stalled, then release.
    cyc(1'b1, 96'hA, 1'b1, 1'b0);
    cyc(1'b1, 96'hB, 1'b0, 1'b0);
    cyc(1'b1, 96'hC, 1'b0, 1'b0);
    cyc(1'b1, 96'hC, 1'b0, 1'b0);
    cyc(1'b1, 96'hC, 1'b1, 1'b0);
    cyc(1'b1, 96'hC, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush while FULL with an offered D.
    cyc(1'b1, 96'hA, 1'b0, 1'b0);
    cyc(1'b1, 96'hB, 1'b0, 1'b0);
    cyc(1'b1, 96'hD, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush on the same cycle as a downstream accept.
    cyc(1'b1, 96'hA, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // out_ready toggling with a continuous input stream.
    cyc(1'b1, 96'h21, 1'b1, 1'b0);
    cyc(1'b1, 96'h22, 1'b0, 1'b0);
    cyc(1'b1, 96'h23, 1'b1, 1'b0);
    cyc(1'b1, 96'h24, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // Counter saturation on the 4-bit lane; flush keeps it, reset clears it.
    cyc(1'b1, 96'h66, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    #4 chk("sat", 0, {80'd0, cnt[0]}, 96'd15);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    #4 chk("sat_after_flush", 0, {80'd0, cnt[0]}, 96'd15);
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    #4 chk("cnt_reset", 0, {80'd0, cnt[0]}, 96'd0);
    chk("cnt_reset", 1, {80'd0, cnt[1]}, 96'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;

    // Random traffic; garbage data whenever in_valid is low.
    repeat (3000) begin
      cyc(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
